axi4_lite_slave_regs: RTL and testbench

AXI4-Lite responder (slave) terminating all five channels and backing them with a small bank of 32-bit control/status registers. It sits at the far end of the AXI4-Lite link from the existing master-side path and returns write responses and read data with OKAY/SLVERR. Register contents are also exported flat for downstream user logic.

---
 rtl/axi4_lite_pkg.sv | 33 +++
 rtl/axi4_lite_regfile.sv | 44 ++++
 rtl/axi4_lite_slave_regs.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_lite_pkg: response codes, FSM encodings, byte-merge helper        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_lite_regfile: NUM_REGS x 32 storage, strobed write, comb read     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_widx,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_wstrb,
  input  logic [IDX_W-1:0]       i_ridx,
  output logic [31:0]            o_rdata,
  output logic [NUM_REGS*32-1:0] o_regs
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (i_we) regs_d[i_widx] = strb_merge(regs_q[i_widx], i_wdata, i_wstrb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read sees the current contents, so a same-edge write is not visible yet.
  assign o_rdata = regs_q[i_ridx];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[32*k +: 32] = regs_q[k];
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axi4_lite_slave_regs: AXI4-Lite responder backed by a register bank    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic [NUM_REGS*32-1:0]  REGS
);

  localparam int IDX_W = $clog2(NUM_REGS);

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             rdy_en_q;
  logic             aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             aw_ok_q, aw_ok_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             w_aw_fire, w_w_fire, w_ar_fire;
  logic             w_aw_in_range, w_ar_in_range;
  logic             w_rf_we;
  logic [IDX_W-1:0] w_rf_widx;
  logic [31:0]      w_rf_wdata, w_rf_rdata;
  logic [3:0]       w_rf_wstrb;
  logic             w_unused;

  assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign w_aw_in_range = ~|AWADDR[ADDR_WIDTH-1:2+IDX_W];
  assign w_ar_in_range = ~|ARADDR[ADDR_WIDTH-1:2+IDX_W];

  // rdy_en_q keeps every READY low until the first edge after reset release.
  assign AWREADY = rdy_en_q && (w_state_q == W_IDLE) && !aw_got_q;
  assign WREADY  = rdy_en_q && (w_state_q == W_IDLE) && !w_got_q;
  assign ARREADY = rdy_en_q && (r_state_q == R_IDLE);

  assign w_aw_fire = AWVALID && AWREADY;
  assign w_w_fire  = WVALID && WREADY;
  assign w_ar_fire = ARVALID && ARREADY;

  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_idx_d   = aw_idx_q;
    aw_ok_d    = aw_ok_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_rf_we    = 1'b0;
    w_rf_widx  = aw_idx_q;
    w_rf_wdata = wdata_q;
    w_rf_wstrb = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_aw_fire) begin
          aw_got_d = 1'b1;
          aw_idx_d = AWADDR[2 +: IDX_W];
          aw_ok_d  = w_aw_in_range;
        end
        if (w_w_fire) begin
          w_got_d = 1'b1;
          wdata_d = WDATA;
          wstrb_d = WSTRB;
        end
        // Commit on the edge that completes the later of the two handshakes.
        if (aw_got_d && w_got_d) begin
          w_rf_we    = aw_ok_d;
          w_rf_widx  = aw_idx_d;
          w_rf_wdata = wdata_d;
          w_rf_wstrb = wstrb_d;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = aw_ok_d ? RESP_OKAY : RESP_SLVERR;
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (w_ar_fire) begin
          rvalid_d  = 1'b1;
          rdata_d   = w_ar_in_range ? w_rf_rdata : 32'h0;
          rresp_d   = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'h0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_en_q  <= 1'b1;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  axi4_lite_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_we    (w_rf_we),
    .i_widx  (w_rf_widx),
    .i_wdata (w_rf_wdata),
    .i_wstrb (w_rf_wstrb),
    .i_ridx  (ARADDR[2 +: IDX_W]),
    .o_rdata (w_rf_rdata),
    .o_regs  (REGS)
  );

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_axi4_lite_slave_regs: vector table + scoreboard bench               |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_axi4_lite_slave_regs;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic        BREADY = 1'b1, RREADY = 1'b1;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic [2:0]  AWPROT = 3'b000, ARPROT = 3'b000;
  logic        AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [255:0] REGS;

  axi4_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .REGS(REGS)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: responses are popped when the handshake is about to complete.
  always @(negedge ACLK) begin
    logic [1:0] be;
    rexp_t      re;
    if (!ARESET) begin
      if (BVALID && BREADY) begin
        chk("b_expected", (bq.size() > 0), 1'b1);
        if (bq.size() > 0) begin
          be = bq.pop_front();
          chk("bresp", BRESP, be);
        end
      end
      if (RVALID && RREADY) begin
        chk("r_expected", (rq.size() > 0), 1'b1);
        if (rq.size() > 0) begin
          re = rq.pop_front();
          chk("rresp", RRESP, re.resp);
          chk("rdata", RDATA, re.data);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && (bq.size() > 0 || rq.size() > 0); i++) @(posedge ACLK);
    #1;
    chk("resp_timeout", (bq.size() == 0 && rq.size() == 0), 1'b1);
    bq.delete();
    rq.delete();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    logic aw_f, w_f;
    bq.push_back(er);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
      @(negedge ACLK);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_f) AWVALID = 1'b0;
      if (w_f)  WVALID = 1'b0;
    end
    chk("aw_w_accept_timeout", (AWVALID || WVALID), 1'b0);
    AWVALID = 1'b0; WVALID = 1'b0;
    drain();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
    logic ar_f;
    rexp_t e;
    e.resp = er; e.data = ed;
    rq.push_back(e);
    ARADDR = a; ARVALID = 1'b1;
    for (int i = 0; i < 20 && ARVALID; i++) begin
      @(negedge ACLK);
      ar_f = ARREADY;
      @(posedge ACLK); #1;
      if (ar_f) ARVALID = 1'b0;
    end
    chk("ar_accept_timeout", ARVALID, 1'b0);
    ARVALID = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[14];
  rexp_t e0;

  initial begin
    vecs[0]  = '{1'b1, 32'h04,       32'hDEADBEEF, 4'hF, OK,  32'h0};
    vecs[1]  = '{1'b0, 32'h04,       32'h0,        4'h0, OK,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'hF, OK,  32'h0};
    vecs[3]  = '{1'b1, 32'h10,       32'hAABBCCDD, 4'h2, OK,  32'h0};
    vecs[4]  = '{1'b0, 32'h10,       32'h0,        4'h0, OK,  32'h1122CC44};
    vecs[5]  = '{1'b1, 32'h1C,       32'h12345678, 4'h0, OK,  32'h0};
    vecs[6]  = '{1'b1, 32'h1D,       32'hFFFFFFFF, 4'h8, OK,  32'h0};
    vecs[7]  = '{1'b0, 32'h1F,       32'h0,        4'h0, OK,  32'hFF000000};
    vecs[8]  = '{1'b1, 32'h40,       32'hCAFEF00D, 4'hF, ERR, 32'h0};
    vecs[9]  = '{1'b0, 32'h40,       32'h0,        4'h0, ERR, 32'h0};
    vecs[10] = '{1'b0, 32'h20,       32'h0,        4'h0, ERR, 32'h0};
    vecs[11] = '{1'b0, 32'h00,       32'h0,        4'h0, OK,  32'h0};
    vecs[12] = '{1'b1, 32'hFFFFFFFC, 32'h87654321, 4'hF, ERR, 32'h0};
    vecs[13] = '{1'b0, 32'h1C,       32'h0,        4'h0, OK,  32'hFF000000};

    // Reset state
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_valids", {BVALID, RVALID}, 2'b00);
    chk("rst_resps", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_regs", REGS, 256'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rel_ready_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(posedge ACLK); #1;
    chk("rel_ready_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

    // AW and W in the same cycle
    bq.push_back(OK);
    AWADDR = 32'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("same_cyc_readies", {AWREADY, WREADY}, 2'b11);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("same_cyc_bvalid", BVALID, 1'b1);
    chk("same_cyc_reg1", REGS[63:32], 32'hDEADBEEF);
    drain();

    // W two cycles ahead of AW
    bq.push_back(OK);
    WDATA = 32'h12345678; WSTRB = 4'b0101; WVALID = 1'b1;
    @(negedge ACLK);
    chk("wfirst_wready", WREADY, 1'b1);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(negedge ACLK);
    chk("wfirst_wready_drop", WREADY, 1'b0);
    chk("wfirst_no_b", BVALID, 1'b0);
    @(posedge ACLK); #1;
    AWADDR = 32'h8; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("wfirst_awready", AWREADY, 1'b1);
    chk("wfirst_reg2_before", REGS[95:64], 32'h0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    chk("wfirst_reg2_after", REGS[95:64], 32'h00340078);
    chk("wfirst_bvalid", BVALID, 1'b1);
    drain();

    // Read held while RREADY low
    RREADY = 1'b0;
    e0.resp = OK; e0.data = 32'hDEADBEEF;
    rq.push_back(e0);
    ARADDR = 32'h4; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("hold_arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("hold_rvalid", RVALID, 1'b1);
      chk("hold_rdata", RDATA, 32'hDEADBEEF);
      chk("hold_rresp", RRESP, OK);
      chk("hold_arready_low", ARREADY, 1'b0);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    drain();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      else               do_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
    end

    // Write commit and AR handshake on the same edge
    bq.push_back(OK);
    e0.resp = OK; e0.data = 32'h0;
    rq.push_back(e0);
    AWADDR = 32'hC; WDATA = 32'hAAAA5555; WSTRB = 4'hF; ARADDR = 32'hC;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("same_edge_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    drain();
    do_read(32'hC, OK, 32'hAAAA5555);

    chk("final_regs", REGS, {32'hFF000000, 32'h0, 32'h0, 32'h1122CC44,
                             32'hAAAA5555, 32'h00340078, 32'hDEADBEEF, 32'h0});

    // Reset while B and R are pending
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 32'h4; WDATA = 32'h1; WSTRB = 4'hF; ARADDR = 32'h4;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    chk("pend_valids", {BVALID, RVALID}, 2'b11);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    #1;
    chk("midrst_valids", {BVALID, RVALID}, 2'b00);
    chk("midrst_regs", REGS, 256'h0);
    chk("midrst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("midrst_rdata", RDATA, 32'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("midrst_ready_return", {AWREADY, WREADY, ARREADY}, 3'b111);

    // A lone W capture must not survive reset
    WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    AWADDR = 32'h0; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    chk("partial_dropped_no_b", BVALID, 1'b0);
    chk("partial_dropped_reg0", REGS[31:0], 32'h0);
    @(posedge ACLK); #1;
    bq.push_back(OK);
    WDATA = 32'h77; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(negedge ACLK);
    chk("partial_new_reg0", REGS[31:0], 32'h77);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
